// File: rtl/spictrl_apb_wrap.sv
// APB-slave SPI controller, master or slave, single-word buffers.
// GRLIB-style port naming; SPI pins go straight to pads.
module spictrl_apb_wrap #(
    parameter int          SSWIDTH   = 8,
    parameter logic [31:0] CAP_VALUE = 32'h0801_0100
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               apbi_psel,
    input  logic               apbi_penable,
    input  logic [31:0]        apbi_paddr,
    input  logic               apbi_pwrite,
    input  logic [31:0]        apbi_pwdata,
    input  logic               apbi_testen,
    input  logic               apbi_testrst,
    input  logic               apbi_scanen,
    input  logic               apbi_testoen,
    output logic [31:0]        apbo_prdata,
    output logic               apbo_pirq,
    input  logic               spii_miso,
    input  logic               spii_mosi,
    input  logic               spii_sck,
    input  logic               spii_spisel,
    input  logic               spii_astart,
    input  logic               spii_cstart,
    input  logic               spii_ignore,
    input  logic               spii_io2,
    input  logic               spii_io3,
    output logic               spio_miso,
    output logic               spio_misooen,
    output logic               spio_mosi,
    output logic               spio_mosioen,
    output logic               spio_sck,
    output logic               spio_sckoen,
    output logic               spio_enable,
    output logic               spio_astart,
    output logic               spio_aready,
    output logic               spio_io2,
    output logic               spio_io2oen,
    output logic               spio_io3,
    output logic               spio_io3oen,
    output logic [SSWIDTH-1:0] slvsel
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [31:0]          r_mode;
    logic [3:0]           r_mask;
    logic                 r_lt;
    logic                 r_ov;
    logic                 r_ne;
    logic                 r_nf;
    logic [31:0]          r_tx;
    logic [31:0]          r_rx;
    logic [31:0]          r_txsh;
    logic [31:0]          r_rxsh;
    logic [SSWIDTH-1:0]   r_slvsel;
    logic [5:0]           r_edge;
    logic [4:0]           r_div;
    logic                 r_sck;
    logic [1:0]           r_sck_s;
    logic [1:0]           r_sel_s;
    logic [1:0]           r_mosi_s;
    logic                 r_sck_d;

    logic                 w_cpol;
    logic                 w_cpha;
    logic                 w_rev;
    logic                 w_ms;
    logic                 w_en;
    logic [3:0]           w_len;
    logic [3:0]           w_pm;
    logic                 w_master;
    logic                 w_sel;
    logic                 w_slave;
    logic                 w_wr;
    logic                 w_rd_acc;
    logic [5:0]           w_addr;
    logic [4:0]           w_lenm1;
    logic [4:0]           w_div_max;
    logic [5:0]           w_edge_max;
    logic                 w_tick;
    logic                 w_in;
    logic                 w_txbit;
    logic                 w_samp;
    logic [31:0]          w_rx_word;
    logic                 w_start;
    logic                 w_abort;
    logic                 w_run;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_cpol   = r_mode[29];
    assign w_cpha   = r_mode[28];
    assign w_rev    = r_mode[26];
    assign w_ms     = r_mode[25];
    assign w_en     = r_mode[24];
    assign w_len    = r_mode[23:20];
    assign w_pm     = r_mode[19:16];
    assign w_master = w_en & w_ms;
    assign w_sel    = ~r_sel_s[1];
    assign w_slave  = w_en & ~w_ms & w_sel;

    assign w_wr     = apbi_psel & apbi_penable & apbi_pwrite;
    assign w_rd_acc = apbi_psel & apbi_penable & ~apbi_pwrite;
    assign w_addr   = apbi_paddr[7:2];

    // Word length minus one: 0 means 32 bits, 1..3 clamp to 4 bits.
    assign w_lenm1    = (w_len == 4'd0) ? 5'd31 :
                        (w_len < 4'd4)  ? 5'd3  : {1'b0, w_len};
    assign w_div_max  = {w_pm, 1'b1};
    assign w_edge_max = {w_lenm1, 1'b1};

    // Master ticks on its own divider, slave on synchronized SCK edges.
    assign w_tick = w_master ? (r_div == w_div_max)
                             : (r_sck_s[1] ^ r_sck_d);
    assign w_in   = w_master ? spii_miso : r_mosi_s[1];
    assign w_txbit = w_rev ? r_txsh[w_lenm1] : r_txsh[0];
    // Even edges are leading; CPHA moves sampling to the trailing edge.
    assign w_samp = ~r_edge[0] ^ w_cpha;
    // LSB-first words arrive at the top and are right-aligned here.
    assign w_rx_word = w_rev ? r_rxsh : (r_rxsh >> (~w_lenm1));
    assign w_run  = (r_state == S_RUN) & ~w_abort;

    // Shifter state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Shifter next state: start, abort on disable/deselect, finish.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((w_master && !r_nf) || w_slave) begin
                    w_start      = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_en || (!w_ms && !w_sel)) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_tick && r_edge == w_edge_max) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Two-flop synchronizers for slave pad inputs plus SCK edge history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sck_s  <= 2'b00;
            r_sel_s  <= 2'b11;
            r_mosi_s <= 2'b00;
            r_sck_d  <= 1'b0;
        end else begin
            r_sck_s  <= {r_sck_s[0], spii_sck};
            r_sel_s  <= {r_sel_s[0], spii_spisel};
            r_mosi_s <= {r_mosi_s[0], spii_mosi};
            r_sck_d  <= r_sck_s[1];
        end
    end

    // Shift datapath: SCK generation, bit sampling and shifting out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_txsh <= '0;
            r_rxsh <= '0;
            r_edge <= '0;
            r_div  <= '0;
            r_sck  <= 1'b0;
        end else if (w_start) begin
            r_txsh <= r_tx;
            r_rxsh <= '0;
            r_edge <= '0;
            r_div  <= '0;
            r_sck  <= w_cpol;
        end else if (w_run) begin
            if (w_master)
                r_div <= (r_div == w_div_max) ? 5'd0 : r_div + 5'd1;
            if (w_tick) begin
                r_edge <= r_edge + 6'd1;
                if (w_master) r_sck <= ~r_sck;
                if (w_samp)
                    r_rxsh <= w_rev ? {r_rxsh[30:0], w_in}
                                    : {w_in, r_rxsh[31:1]};
                else if (r_edge != 6'd0)
                    r_txsh <= w_rev ? {r_txsh[30:0], 1'b0}
                                    : {1'b0, r_txsh[31:1]};
            end
        end else begin
            r_sck <= w_cpol;
        end
    end

    // APB register writes, event flags and word completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode   <= '0;
            r_mask   <= '0;
            r_lt     <= 1'b0;
            r_ov     <= 1'b0;
            r_ne     <= 1'b0;
            r_nf     <= 1'b1;
            r_tx     <= '0;
            r_rx     <= '0;
            r_slvsel <= '1;
        end else begin
            if (w_wr) begin
                case (w_addr)
                    6'h08: r_mode <= apbi_pwdata;
                    6'h09: begin
                        if (apbi_pwdata[14]) r_lt <= 1'b0;
                        if (apbi_pwdata[12]) r_ov <= 1'b0;
                    end
                    6'h0A: r_mask <= {apbi_pwdata[14], apbi_pwdata[12],
                                      apbi_pwdata[9], apbi_pwdata[8]};
                    6'h0C: begin
                        if (r_nf) begin
                            r_tx <= apbi_pwdata;
                            r_nf <= 1'b0;
                        end
                    end
                    6'h0E: r_slvsel <= apbi_pwdata[SSWIDTH-1:0];
                    default: ;
                endcase
            end
            if (w_rd_acc && w_addr == 6'h0D) r_ne <= 1'b0;
            if (r_state == S_DONE) begin
                r_nf <= 1'b1;
                r_lt <= 1'b1;
                if (r_ne) begin
                    r_ov <= 1'b1;
                end else begin
                    r_rx <= w_rx_word;
                    r_ne <= 1'b1;
                end
            end
        end
    end

    // APB read mux, zero when not selected or unmapped.
    always_comb begin
        w_rdata = '0;
        if (apbi_psel) begin
            case (w_addr)
                6'h00: w_rdata = CAP_VALUE;
                6'h08: w_rdata = r_mode;
                6'h09: w_rdata = {17'd0, r_lt, 1'b0, r_ov, 2'b00,
                                  r_ne, r_nf, 8'd0};
                6'h0A: w_rdata = {17'd0, r_mask[3], 1'b0, r_mask[2],
                                  2'b00, r_mask[1], r_mask[0], 8'd0};
                6'h0D: w_rdata = r_rx;
                6'h0E: w_rdata = 32'(r_slvsel);
                default: w_rdata = '0;
            endcase
        end
    end

    assign apbo_prdata  = w_rdata;
    assign apbo_pirq    = |({r_lt, r_ov, r_ne, r_nf} & r_mask);

    assign spio_miso    = w_txbit;
    assign spio_mosi    = w_txbit;
    assign spio_sck     = r_sck;
    assign spio_misooen = ~w_slave;
    assign spio_mosioen = ~w_master;
    assign spio_sckoen  = ~w_master;
    assign spio_enable  = w_en;
    assign spio_astart  = 1'b0;
    assign spio_aready  = 1'b0;
    assign spio_io2     = 1'b0;
    assign spio_io3     = 1'b0;
    assign spio_io2oen  = 1'b1;
    assign spio_io3oen  = 1'b1;
    assign slvsel       = r_slvsel;

    assign w_unused = ^{apbi_testen, apbi_testrst, apbi_scanen,
                        apbi_testoen, apbi_paddr[31:8],
                        apbi_paddr[1:0], spii_astart, spii_cstart,
                        spii_ignore, spii_io2, spii_io3};

endmodule

// File: tb/tb_spictrl_apb_wrap.sv
// Bench for spictrl_apb_wrap: register table, loopback and
// master-to-slave transfers between two instances.
module tb_spictrl_apb_wrap;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rstn;
    logic        psel_m;
    logic        psel_s;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        loop;

    logic [31:0] prdata_m, prdata_s;
    logic        irq_m, irq_s;
    logic        m_miso, m_misooen, m_mosi, m_mosioen, m_sck, m_sckoen;
    logic        m_en, m_astart, m_aready, m_io2, m_io2oen, m_io3, m_io3oen;
    logic        s_miso, s_misooen, s_mosi, s_mosioen, s_sck, s_sckoen;
    logic        s_en, s_astart, s_aready, s_io2, s_io2oen, s_io3, s_io3oen;
    logic [7:0]  m_slvsel, s_slvsel;
    logic        m_miso_in;

    int n_checks = 0;
    int n_errors = 0;
    int m_pulses = 0;
    int m_high   = 0;

    assign m_miso_in = loop ? m_mosi : s_miso;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge m_sck) m_pulses <= m_pulses + 1;
    always @(posedge clk) if (m_sck) m_high <= m_high + 1;

    spictrl_apb_wrap u_m (
        .clk(clk), .rstn(rstn),
        .apbi_psel(psel_m), .apbi_penable(penable),
        .apbi_paddr(paddr), .apbi_pwrite(pwrite),
        .apbi_pwdata(pwdata),
        .apbi_testen(1'b0), .apbi_testrst(1'b0),
        .apbi_scanen(1'b0), .apbi_testoen(1'b0),
        .apbo_prdata(prdata_m), .apbo_pirq(irq_m),
        .spii_miso(m_miso_in), .spii_mosi(1'b0),
        .spii_sck(1'b0), .spii_spisel(1'b1),
        .spii_astart(1'b0), .spii_cstart(1'b0),
        .spii_ignore(1'b0), .spii_io2(1'b0), .spii_io3(1'b0),
        .spio_miso(m_miso), .spio_misooen(m_misooen),
        .spio_mosi(m_mosi), .spio_mosioen(m_mosioen),
        .spio_sck(m_sck), .spio_sckoen(m_sckoen),
        .spio_enable(m_en), .spio_astart(m_astart),
        .spio_aready(m_aready), .spio_io2(m_io2),
        .spio_io2oen(m_io2oen), .spio_io3(m_io3),
        .spio_io3oen(m_io3oen), .slvsel(m_slvsel)
    );

    spictrl_apb_wrap u_s (
        .clk(clk), .rstn(rstn),
        .apbi_psel(psel_s), .apbi_penable(penable),
        .apbi_paddr(paddr), .apbi_pwrite(pwrite),
        .apbi_pwdata(pwdata),
        .apbi_testen(1'b0), .apbi_testrst(1'b0),
        .apbi_scanen(1'b0), .apbi_testoen(1'b0),
        .apbo_prdata(prdata_s), .apbo_pirq(irq_s),
        .spii_miso(1'b0), .spii_mosi(m_mosi),
        .spii_sck(m_sck), .spii_spisel(m_slvsel[0]),
        .spii_astart(1'b0), .spii_cstart(1'b0),
        .spii_ignore(1'b0), .spii_io2(1'b0), .spii_io3(1'b0),
        .spio_miso(s_miso), .spio_misooen(s_misooen),
        .spio_mosi(s_mosi), .spio_mosioen(s_mosioen),
        .spio_sck(s_sck), .spio_sckoen(s_sckoen),
        .spio_enable(s_en), .spio_astart(s_astart),
        .spio_aready(s_aready), .spio_io2(s_io2),
        .spio_io2oen(s_io2oen), .spio_io3(s_io3),
        .spio_io3oen(s_io3oen), .slvsel(s_slvsel)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apb_wr(input bit slv, input logic [7:0] a,
                          input logic [31:0] d);
        @(negedge clk);
        psel_m  = !slv;
        psel_s  = slv;
        paddr   = {24'h0, a};
        pwrite  = 1'b1;
        pwdata  = d;
        penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel_m  = 1'b0;
        psel_s  = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_rd(input bit slv, input logic [7:0] a,
                          output logic [31:0] d);
        @(negedge clk);
        psel_m  = !slv;
        psel_s  = slv;
        paddr   = {24'h0, a};
        pwrite  = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1 d = slv ? prdata_s : prdata_m;
        @(negedge clk);
        psel_m  = 1'b0;
        psel_s  = 1'b0;
        penable = 1'b0;
    endtask

    task automatic rd_chk(input bit slv, input logic [7:0] a,
                          input logic [31:0] exp, input string name);
        logic [31:0] d;
        apb_rd(slv, a, d);
        check(name, d, exp);
    endtask

    vec_t        tbl[20];
    logic [31:0] rd;
    int          p0;
    int          h0;

    initial begin
        tbl[0]  = '{1'b0, 8'h00, 32'h0, 32'h0801_0100};
        tbl[1]  = '{1'b0, 8'h20, 32'h0, 32'h0000_0000};
        tbl[2]  = '{1'b0, 8'h24, 32'h0, 32'h0000_0100};
        tbl[3]  = '{1'b0, 8'h28, 32'h0, 32'h0000_0000};
        tbl[4]  = '{1'b0, 8'h38, 32'h0, 32'h0000_00FF};
        tbl[5]  = '{1'b0, 8'h34, 32'h0, 32'h0000_0000};
        tbl[6]  = '{1'b1, 8'h00, 32'h0002_0000, 32'h0};
        tbl[7]  = '{1'b0, 8'h00, 32'h0, 32'h0801_0100};
        tbl[8]  = '{1'b1, 8'h20, 32'h0F00_0000, 32'h0};
        tbl[9]  = '{1'b0, 8'h20, 32'h0, 32'h0F00_0000};
        tbl[10] = '{1'b1, 8'h20, 32'h0000_0000, 32'h0};
        tbl[11] = '{1'b1, 8'h28, 32'hFFFF_FFFF, 32'h0};
        tbl[12] = '{1'b0, 8'h28, 32'h0, 32'h0000_5300};
        tbl[13] = '{1'b1, 8'h28, 32'h0000_0000, 32'h0};
        tbl[14] = '{1'b1, 8'h3C, 32'h1234_5678, 32'h0};
        tbl[15] = '{1'b0, 8'h3C, 32'h0, 32'h0000_0000};
        tbl[16] = '{1'b1, 8'h38, 32'h0000_005A, 32'h0};
        tbl[17] = '{1'b0, 8'h38, 32'h0, 32'h0000_005A};
        tbl[18] = '{1'b1, 8'h38, 32'h0000_00FF, 32'h0};
        tbl[19] = '{1'b0, 8'h2C, 32'h0, 32'h0000_0000};

        rstn = 1'b0; psel_m = 1'b0; psel_s = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0; loop = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        check("reset slvsel", {24'h0, m_slvsel}, 32'hFF);
        check("reset oen", {29'h0, m_sckoen, m_mosioen, m_misooen},
              32'h7);
        check("reset io oen", {30'h0, m_io2oen, m_io3oen}, 32'h3);
        check("reset pins", {25'h0, m_sck, m_mosi, m_miso, m_en,
              m_astart, m_aready, irq_m}, 32'h0);
        check("reset prdata idle", prdata_m, 32'h0);

        for (int i = 0; i < 20; i++) begin
            if (tbl[i].wr) begin
                apb_wr(1'b0, tbl[i].addr, tbl[i].data);
            end else begin
                apb_rd(1'b0, tbl[i].addr, rd);
                check($sformatf("vec%0d reg%02h", i, tbl[i].addr),
                      rd, tbl[i].exp);
            end
        end

        apb_wr(1'b0, 8'h28, 32'h0000_0100);
        #1 check("irq nf masked", {31'h0, irq_m}, 32'h1);
        apb_wr(1'b0, 8'h28, 32'h0);
        #1 check("irq unmasked", {31'h0, irq_m}, 32'h0);

        apb_wr(1'b0, 8'h20, 32'h0770_0000);
        @(negedge clk);
        check("master oen", {29'h0, m_sckoen, m_mosioen, m_misooen},
              32'h1);
        p0 = m_pulses;
        h0 = m_high;
        apb_wr(1'b0, 8'h30, 32'h0000_00A5);
        repeat (60) @(posedge clk);
        check("lb8 pulses", 32'(m_pulses - p0), 32'd8);
        check("lb8 sck high clks", 32'(m_high - h0), 32'd16);
        rd_chk(1'b0, 8'h24, 32'h0000_4300, "lb8 event");
        rd_chk(1'b0, 8'h34, 32'h0000_00A5, "lb8 rx");
        rd_chk(1'b0, 8'h24, 32'h0000_4100, "lb8 ne cleared");

        apb_wr(1'b0, 8'h24, 32'h0000_5000);
        rd_chk(1'b0, 8'h24, 32'h0000_0100, "event w1c");
        apb_wr(1'b0, 8'h28, 32'h0000_4000);
        #1 check("irq before lt", {31'h0, irq_m}, 32'h0);
        apb_wr(1'b0, 8'h30, 32'h0000_003C);
        repeat (60) @(posedge clk);
        #1 check("irq on lt", {31'h0, irq_m}, 32'h1);
        rd_chk(1'b0, 8'h34, 32'h0000_003C, "irq rx");
        apb_wr(1'b0, 8'h24, 32'h0000_4000);
        #1 check("irq cleared", {31'h0, irq_m}, 32'h0);
        apb_wr(1'b0, 8'h28, 32'h0);

        apb_wr(1'b0, 8'h20, 32'h0330_0000);
        p0 = m_pulses;
        apb_wr(1'b0, 8'h30, 32'h0000_01F6);
        repeat (40) @(posedge clk);
        check("len4 pulses", 32'(m_pulses - p0), 32'd4);
        rd_chk(1'b0, 8'h34, 32'h0000_0006, "len4 lsb rx");

        apb_wr(1'b0, 8'h20, 32'h0300_0000);
        p0 = m_pulses;
        apb_wr(1'b0, 8'h30, 32'hDEAD_BEEF);
        repeat (200) @(posedge clk);
        check("len32 pulses", 32'(m_pulses - p0), 32'd32);
        rd_chk(1'b0, 8'h34, 32'hDEAD_BEEF, "len32 lsb rx");

        apb_wr(1'b0, 8'h20, 32'h0770_0000);
        apb_wr(1'b0, 8'h24, 32'h0000_5000);
        p0 = m_pulses;
        apb_wr(1'b0, 8'h30, 32'h0000_0011);
        repeat (60) @(posedge clk);
        apb_wr(1'b0, 8'h30, 32'h0000_0022);
        apb_wr(1'b0, 8'h30, 32'h0000_0033);
        repeat (60) @(posedge clk);
        check("ovr pulses", 32'(m_pulses - p0), 32'd16);
        rd_chk(1'b0, 8'h24, 32'h0000_5300, "ovr event");
        rd_chk(1'b0, 8'h34, 32'h0000_0011, "ovr rx holds first");
        rd_chk(1'b0, 8'h24, 32'h0000_5100, "ovr ne cleared");

        loop = 1'b0;
        apb_wr(1'b0, 8'h24, 32'h0000_5000);
        apb_wr(1'b1, 8'h20, 32'h35F0_0000);
        apb_wr(1'b1, 8'h30, 32'h0000_BEEF);
        apb_wr(1'b0, 8'h20, 32'h37F3_0000);
        apb_wr(1'b0, 8'h38, 32'h0000_00FE);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("slave oen", {29'h0, s_sckoen, s_mosioen, s_misooen},
              32'h6);
        check("cpol idle", {31'h0, m_sck}, 32'h1);
        apb_wr(1'b0, 8'h30, 32'h0000_1234);
        repeat (320) @(posedge clk);
        apb_wr(1'b0, 8'h38, 32'h0000_00FF);
        repeat (5) @(posedge clk);
        rd_chk(1'b1, 8'h24, 32'h0000_4300, "slave event");
        rd_chk(1'b0, 8'h34, 32'h0000_BEEF, "master rx from slave");
        rd_chk(1'b1, 8'h34, 32'h0000_1234, "slave rx from master");
        @(negedge clk);
        check("cpol after", {31'h0, m_sck}, 32'h1);

        loop = 1'b1;
        apb_wr(1'b0, 8'h20, 32'h0770_0000);
        apb_wr(1'b0, 8'h24, 32'h0000_5000);
        p0 = m_pulses;
        apb_wr(1'b0, 8'h30, 32'h0000_005A);
        repeat (10) @(posedge clk);
        apb_wr(1'b0, 8'h20, 32'h0000_0000);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("abort sck idle", {31'h0, m_sck}, 32'h0);
        check("abort oen", {29'h0, m_sckoen, m_mosioen, m_misooen},
              32'h7);
        check("abort short", {31'h0, (m_pulses - p0) < 8}, 32'h1);
        apb_rd(1'b0, 8'h24, rd);
        check("abort no event", rd & 32'h0000_5200, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spictrl_apb_wrap.md
Name: spictrl_apb_wrap

Overview:
- APB-slave SPI controller with GRLIB-style port naming.
- Operates as SPI master (drives SCK/MOSI, samples MISO) or SPI slave (samples external SCK/MOSI under SPISEL, drives MISO).
- Single-word TX/RX buffers, programmable word length, clock prescaler, CPOL/CPHA, bit order, level interrupt.
- Sits on the peripheral APB bus; SPI pins connect to pads.

Parameters:
- SSWIDTH, 8, number of slave-select outputs.
- CAP_VALUE, 32'h0801_0100, constant read from the capability register.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- apbi_psel  in  1  APB select.
- apbi_penable  in  1  APB access phase.
- apbi_paddr  in  32  byte address; only bits [7:2] decoded.
- apbi_pwrite  in  1  1 = write.
- apbi_pwdata  in  32  write data.
- apbi_testen, apbi_testrst, apbi_scanen, apbi_testoen  in  1 each  DFT inputs; ignored.
- apbo_prdata  out  32  read data.
- apbo_pirq  out  1  interrupt, level high.
- spii_miso, spii_mosi, spii_sck, spii_spisel  in  1 each  SPI pad inputs.
- spii_astart, spii_cstart, spii_ignore, spii_io2, spii_io3  in  1 each  ignored.
- spio_miso, spio_mosi, spio_sck  out  1 each  SPI pad outputs.
- spio_misooen, spio_mosioen, spio_sckoen  out  1 each  output enables, active low.
- spio_enable  out  1  mirrors MODE.EN.
- spio_astart, spio_aready, spio_io2, spio_io3  out  1 each  constant 0.
- spio_io2oen, spio_io3oen  out  1 each  constant 1.
- slvsel  out  SSWIDTH  slave selects, active low.

Behaviour:
- APB access:
  - Zero wait states; no pready port.
  - Write commits on the clk edge where psel & penable & pwrite.
  - apbo_prdata is combinational from paddr[7:2] while psel = 1, else 0.
  - Unmapped addresses read 0; writes to them are ignored.
- Register map (byte offsets):
  - 0x00 CAP: RO, returns CAP_VALUE; writes ignored.
  - 0x20 MODE: RW, reset 0. Fields: [29] CPOL, [28] CPHA, [26] REV (1 = MSB first), [25] MS (1 = master), [24] EN, [23:20] LEN, [19:16] PM.
  - 0x24 EVENT: [14] LT, write-1-to-clear; [12] OV, write-1-to-clear; [9] NE, RO; [8] NF, RO. Reset: NF = 1, others 0.
  - 0x28 MASK: RW, same bit positions, reset 0.
  - 0x30 TX: WO. Accepted only if NF = 1, otherwise ignored. Accepting clears NF.
  - 0x34 RX: RO. Read returns the received word right-aligned and clears NE.
  - 0x38 SLVSEL: RW, reset all ones; drives slvsel directly.
- Word length: LEN = 0 → 32 bits; LEN 1..3 → 4 bits; otherwise LEN+1 bits. TX uses the low bits of the written word.
- Master mode (EN = 1, MS = 1):
  - A transfer starts the cycle after TX is accepted while idle.
  - SCK half-period = 2*(PM+1) clk cycles; idle SCK level = CPOL.
  - CPHA = 0: MOSI valid before the first edge, sample on leading edges.
  - CPHA = 1: shift out on leading edges, sample on trailing edges.
  - After the last sample: RX ← shift register; NE = 1, LT = 1, NF = 1; SCK returns to CPOL.
- Slave mode (EN = 1, MS = 0):
  - spii_sck, spii_spisel and spii_mosi pass through 2-flop synchronizers; edges are detected on synchronized SCK.
  - Active only while synchronized spisel = 0. Same CPOL/CPHA sampling rules apply; MISO shifts from the TX word.
  - Completion is identical to master mode. Spisel deasserting mid-word aborts the word with no event.
- Overrun: completion while NE = 1 sets OV and leaves RX unchanged.
- Output enables:
  - Master: sckoen = 0, mosioen = 0, misooen = 1.
  - Slave, selected: misooen = 0, others 1.
  - EN = 0: all 1.
- EN cleared mid-transfer: transfer aborts, shifter idles, SCK = CPOL, no event raised.
- Interrupt: apbo_pirq = OR over (EVENT & MASK) bits 14, 12, 9, 8.
- Reset values: all outputs 0 except slvsel = all ones and every *oen = 1.

Test Plan:
- After reset, read 0x00 → 0x08010100; read 0x20 → 0; read 0x24 → 0x100; slvsel = 0xFF.
- Write 0x00020000 to 0x00, read 0x00 → still 0x08010100; write 0x0F000000 to MODE → read back 0x0F000000.
- Master loopback (spio_mosi tied to spii_miso), MODE = EN|MS|REV, LEN = 7, PM = 0, TX = 0xA5:
  - 8 SCK pulses, each 4 clk.
  - RX = 0xA5; EVENT reads 0x4300 (LT, NE, NF).
  - RX read clears NE.
- MASK = 0x4000 with a transfer completing → pirq high; write 0x4000 to EVENT → pirq low.
- Two completions without an RX read → OV set; RX holds the first word. A TX write while NF = 0 is ignored.
- Master instance driving a slave instance, LEN = 15, CPOL = 1, CPHA = 1:
  - Master TX = 0x1234, slave TX = 0xBEEF.
  - Result: master RX = 0xBEEF, slave RX = 0x1234.
